// File: rtl/sparse_input_queue_if.sv
// Handshake bundle between the pixel source / first hidden layer and the sparse input queue.
interface sparse_input_queue_if #(
   parameter int unsigned PIXEL_W = 8,
   parameter int unsigned INDEX_W = 10,
   parameter int unsigned CNT_W   = 9
);
   logic               start;
   logic               pixelValid;
   logic [PIXEL_W-1:0] pixelValue;
   logic [PIXEL_W-1:0] threshold;
   logic               dequeue;
   logic [INDEX_W-1:0] indexOut;
   logic [PIXEL_W-1:0] valueOut;
   logic               queueEmpty;
   logic [CNT_W-1:0]   count;
   logic               loadDone;
   logic               finished;
   logic               overflow;

   modport master (
      output start, pixelValid, pixelValue, threshold, dequeue,
      input  indexOut, valueOut, queueEmpty, count, loadDone, finished, overflow
   );

   modport slave (
      input  start, pixelValid, pixelValue, threshold, dequeue,
      output indexOut, valueOut, queueEmpty, count, loadDone, finished, overflow
   );
endinterface

// File: rtl/sparse_input_queue.sv
// Thresholded input-index queue: pixels at or above threshold are pushed as {index, value}
// into a bounded show-ahead FIFO that the first hidden layer drains.
module sparse_input_queue #(
   parameter int unsigned NUM_NODES = 784,
   parameter int unsigned PIXEL_W   = 8,
   parameter int unsigned INDEX_W   = 10,
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned CNT_W     = 9
) (
   input logic                 clk,
   input logic                 reset,
   sparse_input_queue_if.slave q
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

   state_e             state_q, state_d;
   logic [INDEX_W-1:0] pix_idx_q, pix_idx_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               load_done_q, load_done_d;
   logic               finished_q, finished_d;
   logic               overflow_q, overflow_d;

   logic [INDEX_W-1:0] mem_idx [DEPTH];
   logic [PIXEL_W-1:0] mem_val [DEPTH];

   logic empty, full, accept, qualify, do_deq, do_enq, last_pix;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(DEPTH));
   assign accept   = (state_q == StLoad) && q.pixelValid && !q.start;
   assign qualify  = (q.pixelValue >= q.threshold);
   assign do_deq   = q.dequeue && !empty && !q.start;
   // A full queue still accepts when the head is popped on the same edge.
   assign do_enq   = accept && qualify && (!full || do_deq);
   assign last_pix = accept && (pix_idx_q == INDEX_W'(NUM_NODES - 1));

   always_comb begin
      state_d     = state_q;
      pix_idx_d   = pix_idx_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      load_done_d = load_done_q;
      overflow_d  = overflow_q;
      if (q.start) begin
         state_d     = StLoad;
         pix_idx_d   = '0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         load_done_d = 1'b0;
         overflow_d  = 1'b0;
      end else begin
         unique case (state_q)
            StLoad: begin
               if (last_pix) begin
                  state_d     = StDrain;
                  load_done_d = 1'b1;
               end
            end
            StIdle, StDrain: state_d = state_q;
            default: state_d = StIdle;
         endcase
         if (accept) pix_idx_d = pix_idx_q + INDEX_W'(1);
         if (do_enq) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (do_deq) rd_ptr_d = ptr_inc(rd_ptr_q);
         if (do_enq && !do_deq) count_d = count_q + CNT_W'(1);
         else if (!do_enq && do_deq) count_d = count_q - CNT_W'(1);
         if (accept && qualify && !do_enq) overflow_d = 1'b1;
      end
      finished_d = load_done_d && (count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= StIdle;
         pix_idx_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         load_done_q <= 1'b0;
         finished_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pix_idx_q   <= pix_idx_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         load_done_q <= load_done_d;
         finished_q  <= finished_d;
         overflow_q  <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_enq) begin
         mem_idx[wr_ptr_q] <= pix_idx_q;
         mem_val[wr_ptr_q] <= q.pixelValue;
      end
   end

   assign q.indexOut   = empty ? '0 : mem_idx[rd_ptr_q];
   assign q.valueOut   = empty ? '0 : mem_val[rd_ptr_q];
   assign q.queueEmpty = empty;
   assign q.count      = count_q;
   assign q.loadDone   = load_done_q;
   assign q.finished   = finished_q;
   assign q.overflow   = overflow_q;
endmodule

// File: tb/tb_sparse_input_queue.sv
// Bench for sparse_input_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sparse_input_queue;
   localparam int unsigned NN = 10;
   localparam int unsigned PW = 8;
   localparam int unsigned IW = 4;
   localparam int unsigned DP = 4;
   localparam int unsigned CW = 3;

   logic clk = 1'b0;
   logic reset;

   initial forever #5 clk = ~clk;

   sparse_input_queue_if #(.PIXEL_W(PW), .INDEX_W(IW), .CNT_W(CW)) bus ();

   sparse_input_queue #(
      .NUM_NODES(NN), .PIXEL_W(PW), .INDEX_W(IW), .DEPTH(DP), .CNT_W(CW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .q    (bus)
   );

   typedef struct packed {
      logic [IW-1:0] idx;
      logic [PW-1:0] val;
   } entry_t;

   entry_t m_q[$];
   int     m_pix;
   bit     m_loading, m_load_done, m_overflow, m_finished, m_valid;
   int     checks = 0;
   int     failures = 0;
   int     max_cnt = 0;
   int     got_idx[$];
   int     got_val[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      m_pix       = 0;
      m_load_done = 0;
      m_overflow  = 0;
   endtask

   // Reference behaviour applied once per rising edge from the inputs held over that edge.
   task automatic tick();
      bit full;
      bit dq;
      @(posedge clk);
      if (!reset) begin
         model_clear();
         m_loading = 0;
      end else if (bus.start) begin
         model_clear();
         m_loading = 1;
      end else begin
         full = (m_q.size() == DP);
         dq   = bus.dequeue && (m_q.size() > 0);
         if (dq) void'(m_q.pop_front());
         if (m_loading && bus.pixelValid) begin
            if (bus.pixelValue >= bus.threshold) begin
               if (!full || dq) m_q.push_back({IW'(m_pix), bus.pixelValue});
               else m_overflow = 1;
            end
            m_pix++;
            if (m_pix == NN) begin
               m_loading   = 0;
               m_load_done = 1;
            end
         end
      end
      m_finished = m_load_done && (m_q.size() == 0);
      m_valid    = 1;
   endtask

   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         check("cmp_empty", bus.queueEmpty, m_q.size() == 0);
         check("cmp_count", bus.count, m_q.size());
         check("cmp_index", bus.indexOut, (m_q.size() == 0) ? 0 : m_q[0].idx);
         check("cmp_value", bus.valueOut, (m_q.size() == 0) ? 0 : m_q[0].val);
         check("cmp_loaddone", bus.loadDone, m_load_done);
         check("cmp_finished", bus.finished, m_finished);
         check("cmp_overflow", bus.overflow, m_overflow);
         if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      end
   end

   task automatic drive(input bit st, input bit pv, input logic [PW-1:0] pval,
                        input logic [PW-1:0] thr, input bit dq);
      @(negedge clk);
      #1;
      if (dq && bus.queueEmpty === 1'b0) begin
         got_idx.push_back(int'(bus.indexOut));
         got_val.push_back(int'(bus.valueOut));
      end
      bus.start      = st;
      bus.pixelValid = pv;
      bus.pixelValue = pval;
      bus.threshold  = thr;
      bus.dequeue    = dq;
      tick();
   endtask

   task automatic start_frame();
      drive(1, 0, 0, 0, 0);
      got_idx.delete();
      got_val.delete();
   endtask

   task automatic drain(input int bound);
      for (int i = 0; i < bound; i++) begin
         drive(0, 0, 0, 0, 1);
         #1;
         if (bus.queueEmpty === 1'b1) break;
      end
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_empty"}, bus.queueEmpty, 1);
      check({tag, "_count"}, bus.count, 0);
      check({tag, "_loaddone"}, bus.loadDone, 0);
      check({tag, "_finished"}, bus.finished, 0);
      check({tag, "_overflow"}, bus.overflow, 0);
      check({tag, "_index"}, bus.indexOut, 0);
      check({tag, "_value"}, bus.valueOut, 0);
   endtask

   int t1_pix[10] = '{0, 0, 200, 0, 150, 255, 0, 128, 0, 90};
   int t1_idx[4]  = '{2, 4, 5, 7};
   int t1_val[4]  = '{200, 150, 255, 128};

   initial begin
      reset          = 1'b0;
      bus.start      = 1'b0;
      bus.pixelValid = 1'b0;
      bus.pixelValue = '0;
      bus.threshold  = '0;
      bus.dequeue    = 1'b0;
      tick();
      tick();
      #1;
      check_reset_values("rst");
      reset = 1'b1;

      // Basic thresholding
      start_frame();
      for (int i = 0; i < 10; i++) drive(0, 1, PW'(t1_pix[i]), 128, 0);
      drain(10);
      check("t1_n", got_idx.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t1_idx%0d", i), got_idx[i], t1_idx[i]);
         check($sformatf("t1_val%0d", i), got_val[i], t1_val[i]);
      end
      check("t1_empty", bus.queueEmpty, 1);
      check("t1_finished", bus.finished, 1);
      check("t1_overflow", bus.overflow, 0);

      // Overflow: all pixels qualify, nothing drained
      start_frame();
      for (int i = 0; i < 10; i++) drive(0, 1, PW'($urandom_range(0, 255)), 0, 0);
      #1;
      check("t2_count", bus.count, 4);
      check("t2_overflow", bus.overflow, 1);
      check("t2_loaddone", bus.loadDone, 1);
      check("t2_finished", bus.finished, 0);
      drain(10);
      check("t2_n", got_idx.size(), 4);
      for (int i = 0; i < 4; i++) check($sformatf("t2_idx%0d", i), got_idx[i], i);
      check("t2_finished_end", bus.finished, 1);

      // Streaming dequeue during load
      start_frame();
      max_cnt = 0;
      for (int i = 0; i < 10; i++) drive(0, 1, PW'($urandom_range(0, 255)), 0, i != 0);
      drain(10);
      check("t3_n", got_idx.size(), 10);
      for (int i = 0; i < 10; i++) check($sformatf("t3_idx%0d", i), got_idx[i], i);
      check("t3_overflow", bus.overflow, 0);
      check("t3_maxcnt", max_cnt, 1);

      // Gapped valid, max threshold, dequeue on empty
      start_frame();
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 8'hFF, 255, 1);
         drive(0, 1, (i == 9) ? 8'hFF : PW'($urandom_range(0, 254)), 255, 0);
         if (i == 8) begin
            #1;
            check("t4_count_pre", bus.count, 0);
            check("t4_empty_pre", bus.queueEmpty, 1);
            check("t4_overflow_pre", bus.overflow, 0);
         end
      end
      #1;
      check("t4_count", bus.count, 1);
      check("t4_index", bus.indexOut, 9);
      check("t4_value", bus.valueOut, 255);
      check("t4_loaddone", bus.loadDone, 1);
      drain(4);
      check("t4_n", got_idx.size(), 1);
      check("t4_finished", bus.finished, 1);

      // Mid-frame reset, then restart during DRAIN
      start_frame();
      for (int i = 0; i < 6; i++) drive(0, 1, 8'd50, 0, 0);
      @(negedge clk);
      #1;
      reset          = 1'b0;
      bus.start      = 1'b1;
      bus.pixelValid = 1'b1;
      bus.dequeue    = 1'b1;
      tick();
      #1;
      check_reset_values("t5_rst");
      reset = 1'b1;
      drive(0, 1, 8'd77, 0, 0);
      #1;
      check("t5_idle_count", bus.count, 0);
      start_frame();
      for (int i = 0; i < 10; i++) drive(0, 1, (i == 3 || i == 6) ? 8'd210 : 8'd10, 200, 0);
      #1;
      check("t5_drain_count", bus.count, 2);
      check("t5_drain_loaddone", bus.loadDone, 1);
      drive(1, 1, 8'd250, 0, 1);
      #1;
      check_reset_values("t5_restart");
      drive(0, 1, 8'd77, 0, 0);
      #1;
      check("t5_new_index", bus.indexOut, 0);
      check("t5_new_value", bus.valueOut, 77);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         #1;
         reset          = ($urandom_range(0, 199) != 0);
         bus.start      = ($urandom_range(0, 39) == 0);
         bus.pixelValid = ($urandom_range(0, 9) < 7);
         bus.pixelValue = PW'($urandom_range(0, 255));
         bus.threshold  = ($urandom_range(0, 4) == 0) ? '0 : PW'($urandom_range(0, 255));
         bus.dequeue    = ($urandom_range(0, 9) < 4);
         tick();
      end
      @(negedge clk);
      #1;
      reset = 1'b1;
      tick();
      @(negedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
